// File: rtl/pipeline_gemv_engine.sv
// Pipelined fixed-point GEMV tile engine.
// Each accepted beat multiplies a ROWS x LANES tile by a LANES vector.
// The products are summed per row and accumulated over k_beats beats.
// The result is then post-processed (raw, scaled, or scaled ReLU) and
// held until the consumer takes it.
module pipeline_gemv_engine #(
    parameter int ROWS       = 4,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int KB_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [KB_WIDTH-1:0]          k_beats,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_tile [ROWS][LANES],
    input  logic signed [DATA_WIDTH-1:0] b_vec  [LANES],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  y      [ROWS],
    output logic                         done_tile,
    output logic                         ovf,
    output logic                         busy
);

    localparam int PW = 2 * DATA_WIDTH;               // full-precision product
    localparam int SW = PW + $clog2(LANES);           // row sum, no overflow
    localparam int XW = ACC_WIDTH + 1;                // rounding headroom
    localparam logic signed [XW-1:0] RND  = XW'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [XW-1:0] MAXV = XW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] MINV = -XW'(1 << (DATA_WIDTH - 1));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                      state_q, state_d;
    logic [KB_WIDTH-1:0]         k_q, beat_q;
    logic [1:0]                  mode_q, drain_q;
    logic signed [PW-1:0]        p1_q [ROWS][LANES];
    logic signed [SW-1:0]        p2_q [ROWS];
    logic signed [SW-1:0]        row_sum [ROWS];
    logic signed [ACC_WIDTH-1:0] acc_q [ROWS];
    logic signed [ACC_WIDTH-1:0] y_q [ROWS];
    logic signed [ACC_WIDTH-1:0] y_next [ROWS];
    logic                        v1_q, v2_q, ovf_q, ovf_next, done_q;
    logic                        accept, last_beat, start_ok, drain_done;

    assign in_ready   = (state_q == S_RUN) && (beat_q < k_q);
    assign accept     = in_valid && in_ready;
    assign last_beat  = accept && (beat_q == k_q - KB_WIDTH'(1));
    assign start_ok   = start && (state_q == S_IDLE);
    // Accumulators hold the final sum two edges into DRAIN; the result is
    // registered on the third edge, which is also the edge that enters OUT.
    assign drain_done = (state_q == S_DRAIN) && (drain_q == 2'd2);

    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done_tile = done_q;
    assign ovf       = ovf_q;
    assign y         = y_q;

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets its default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)      state_d = (k_beats == '0) ? S_OUT : S_RUN;
            S_RUN:   if (last_beat)  state_d = S_DRAIN;
            S_DRAIN: if (drain_done) state_d = S_OUT;
            S_OUT:   if (out_ready)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Tile control: latched parameters, beat counter, drain counter, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            mode_q  <= '0;
            beat_q  <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == S_OUT) && out_ready;
            if (start_ok) begin
                k_q     <= k_beats;
                mode_q  <= mode;
                beat_q  <= '0;
                drain_q <= '0;
            end else begin
                if (accept)               beat_q  <= beat_q + KB_WIDTH'(1);
                if (state_q == S_DRAIN)   drain_q <= drain_q + 2'd1;
            end
        end
    end

    // Per-row sum of the registered lane products.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_sum[r] = '0;
            for (int l = 0; l < LANES; l++)
                row_sum[r] = row_sum[r] + SW'(p1_q[r][l]);
        end
    end

    // Three-stage datapath: products, row sums, accumulation.
    // NOTE: datapath registers are reset too, so a tile that follows a reset can never pick up stale products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                p2_q[r]  <= '0;
                acc_q[r] <= '0;
                for (int l = 0; l < LANES; l++) p1_q[r][l] <= '0;
            end
        end else begin
            v1_q <= accept;
            v2_q <= v1_q && !start_ok;
            for (int r = 0; r < ROWS; r++) begin
                if (accept)
                    for (int l = 0; l < LANES; l++)
                        p1_q[r][l] <= PW'(a_tile[r][l]) * PW'(b_vec[l]);
                p2_q[r] <= row_sum[r];
                if (start_ok)  acc_q[r] <= '0;
                else if (v2_q) acc_q[r] <= acc_q[r] + ACC_WIDTH'(p2_q[r]);
            end
        end
    end

    // Post-processing: round-to-nearest rescale, saturate, optional ReLU.
    always_comb begin
        logic signed [XW-1:0] rnd, shr, sc;
        logic                 sat;
        rnd      = '0;
        shr      = '0;
        sc       = '0;
        sat      = 1'b0;
        ovf_next = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            rnd = XW'(acc_q[r]) + RND;
            shr = rnd >>> FRAC_BITS;
            sat = (shr > MAXV) || (shr < MINV);
            if (shr > MAXV)      sc = MAXV;
            else if (shr < MINV) sc = MINV;
            else                 sc = shr;
            if (mode_q == 2'b10 && sc < 0) sc = '0;
            if (mode_q == 2'b00) begin
                y_next[r] = acc_q[r];
            end else begin
                y_next[r] = ACC_WIDTH'(sc);
                ovf_next  = ovf_next | sat;
            end
        end
    end

    // Result register: loaded when the drain completes, held through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) y_q[r] <= '0;
        end else if (start_ok && k_beats == '0) begin
            ovf_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) y_q[r] <= '0;
        end else if (drain_done) begin
            ovf_q <= ovf_next;
            for (int r = 0; r < ROWS; r++) y_q[r] <= y_next[r];
        end
    end

endmodule

// File: tb/tb_pipeline_gemv_engine.sv
// Self-checking bench for pipeline_gemv_engine.
// Tile vectors come from a table, and expected results flow through a
// scoreboard queue. The multi-cycle corners use hand-written sequences.
module tb_pipeline_gemv_engine;

    localparam int ROWS = 4;
    localparam int LANES = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        k_beats;
    logic [1:0]        mode;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] a_tile [ROWS][LANES];
    logic signed [15:0] b_vec  [LANES];
    logic              out_valid;
    logic              out_ready;
    logic signed [31:0] y [ROWS];
    logic              done_tile;
    logic              ovf;
    logic              busy;

    pipeline_gemv_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_beats(k_beats), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .a_tile(a_tile), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .done_tile(done_tile), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][15:0] a;      // per-row value, replicated across lanes
        logic [15:0]      b;      // replicated across lanes
        int               kb;
        logic [1:0]       mode;
        logic [3:0][31:0] ey;
        bit               eovf;
        int               rd;     // cycles out_ready is held low
    } vec_t;

    typedef struct {
        logic [3:0][31:0] y;
        bit               ovf;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb [$];
    vec_t vecs [10];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a_rest, input logic [15:0] a_row0,
                                input logic [15:0] b, input int kb, input logic [1:0] md,
                                input logic [31:0] y_rest, input logic [31:0] y_row0,
                                input bit eovf, input int rd);
        vec_t v;
        v.a    = {a_rest, a_rest, a_rest, a_row0};
        v.b    = b;
        v.kb   = kb;
        v.mode = md;
        v.ey   = {y_rest, y_rest, y_rest, y_row0};
        v.eovf = eovf;
        v.rd   = rd;
        return v;
    endfunction

    task automatic load_data(input vec_t v);
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < LANES; l++) a_tile[r][l] = v.a[r];
        for (int l = 0; l < LANES; l++) b_vec[l] = v.b;
    endtask

    // Called on a negedge; returns on the following negedge.
    task automatic start_tile(input vec_t v);
        exp_t e;
        load_data(v);
        k_beats = v.kb[7:0];
        mode    = v.mode;
        start   = 1'b1;
        e.y     = v.ey;
        e.ovf   = v.eovf;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives kb beats, optionally with bubbles and spurious start pulses,
    // then measures when out_valid rises.
    task automatic drive_beats(input vec_t v, input bit toggle);
        int sent = 0;
        int guard = 0;
        int n;
        bit acc;
        while (sent < v.kb && guard < 200) begin
            if (toggle && (guard % 2 == 1)) begin
                in_valid = 1'b0;
                start    = 1'b1;
            end else begin
                in_valid = 1'b1;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (acc) sent++;
        end
        in_valid = toggle;
        check("beats_accepted", sent, v.kb);
        if (v.kb > 0) check("in_ready_after_last", in_ready, 0);
        // n=1 is the negedge right after the final accepting edge (or after
        // the start edge when kb==0).
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("out_valid_latency", n, (v.kb == 0) ? 1 : 4);
    endtask

    // Called at a negedge with out_valid high; returns at the negedge after
    // the handshake edge.
    task automatic consume(input int rd);
        exp_t e;
        bit   stable;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("out_valid", out_valid, 1);
        for (int r = 0; r < ROWS; r++)
            check($sformatf("y[%0d]", r), y[r], $signed(e.y[r]));
        check("ovf", ovf, e.ovf);
        out_ready = 1'b0;
        repeat (rd) begin
            @(negedge clk);
            stable = out_valid && (ovf == e.ovf) && !done_tile;
            for (int r = 0; r < ROWS; r++) stable &= (y[r] == $signed(e.y[r]));
            check("hold_stable", stable, 1);
        end
        check("done_before_handshake", done_tile, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("done_pulse", done_tile, 1);
        check("out_valid_dropped", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0] = mk(16'h0100, 16'h0100, 16'h0100, 2, 2'b00, 32'd524288, 32'd524288, 1'b0, 0);
        vecs[1] = mk(16'h0100, 16'h0100, 16'h0100, 2, 2'b01, 32'd2048, 32'd2048, 1'b0, 5);
        vecs[2] = mk(16'h4000, 16'h4000, 16'h4000, 1, 2'b01, 32'd32767, 32'd32767, 1'b1, 0);
        vecs[3] = mk(16'h4000, 16'h4000, 16'h4000, 1, 2'b00, 32'd1073741824, 32'd1073741824, 1'b0, 2);
        vecs[4] = mk(16'h0100, 16'hFF00, 16'h0100, 1, 2'b10, 32'd1024, 32'd0, 1'b0, 0);
        vecs[5] = mk(16'hC000, 16'hC000, 16'h4000, 1, 2'b11, 32'hFFFF8000, 32'hFFFF8000, 1'b1, 0);
        vecs[6] = mk(16'h4000, 16'h4000, 16'h4000, 1, 2'b10, 32'd32767, 32'd32767, 1'b1, 0);
        vecs[7] = mk(16'h0100, 16'h0100, 16'h0100, 0, 2'b01, 32'd0, 32'd0, 1'b0, 3);
        vecs[8] = mk(16'h0180, 16'h0180, 16'hFF80, 3, 2'b01, 32'hFFFFF700, 32'hFFFFF700, 1'b0, 0);
        vecs[9] = mk(16'h0020, 16'h0020, 16'h0001, 1, 2'b01, 32'd1, 32'd1, 1'b0, 0);

        rst_n = 1'b0; start = 1'b0; k_beats = '0; mode = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        load_data(vecs[0]);
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done_tile, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_y0", y[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven tiles.
        for (int i = 0; i < 10; i++) begin
            start_tile(vecs[i]);
            drive_beats(vecs[i], 1'b0);
            consume(vecs[i].rd);
            @(negedge clk);
            check("done_one_cycle", done_tile, 0);
            check("idle_after_done", busy, 0);
        end

        // Bubbles, mid-RUN start pulses, and in_valid while idle.
        v = mk(16'h0100, 16'h0100, 16'h0100, 4, 2'b00, 32'd1048576, 32'd1048576, 1'b0, 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
        end
        start_tile(v);
        drive_beats(v, 1'b1);
        consume(0);
        // Start during the done_tile cycle is taken.
        v = mk(16'h0100, 16'h0100, 16'h0100, 1, 2'b00, 32'd262144, 32'd262144, 1'b0, 0);
        start_tile(v);
        check("b2b_done_low", done_tile, 0);
        check("b2b_busy", busy, 1);
        drive_beats(v, 1'b0);
        consume(0);
        @(negedge clk);

        // Reset mid-tile, then tiles with no residue.
        v = mk(16'h0100, 16'h0100, 16'h0100, 4, 2'b00, 32'd0, 32'd0, 1'b0, 0);
        start_tile(v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y1", y[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        v = mk(16'h0100, 16'h0100, 16'h0100, 1, 2'b00, 32'd262144, 32'd262144, 1'b0, 0);
        start_tile(v);
        drive_beats(v, 1'b0);
        consume(1);
        @(negedge clk);
        v = mk(16'h0100, 16'h0100, 16'h0100, 0, 2'b00, 32'd0, 32'd0, 1'b0, 0);
        start_tile(v);
        drive_beats(v, 1'b0);
        consume(0);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
